slice_grid_scheduler: RTL

// Sequences the 2x2 grid of tensor_slice_int8 instances through a tiled int8 matmul.

---
 rtl/slice_grid_scheduler_if.sv | 36 +++
 rtl/slice_grid_scheduler.sv | 126 ++++++++++++
 2 files changed

// File: rtl/slice_grid_scheduler_if.sv
// Control bundle between the slice-grid scheduler and its operand loader, slice grid and drain logic.
// The master modport is the scheduler side.
interface slice_grid_scheduler_if #(
    parameter int NUM_SLICES = 4
);
    logic                  ap_start;
    logic                  ap_continue;
    logic                  ap_idle;
    logic                  ap_ready;
    logic                  ap_done;
    logic                  operand_req;
    logic                  operand_valid;
    logic [3:0]            tile_m;
    logic [3:0]            tile_n;
    logic [3:0]            tile_k;
    logic                  slice_pe_reset;
    logic [NUM_SLICES-1:0] slice_start;
    logic [NUM_SLICES-1:0] slice_done;
    logic                  drain_valid;
    logic                  drain_ready;
    logic [3:0]            drain_m;
    logic [3:0]            drain_n;
    logic                  err_timeout;

    modport master (
        input  ap_start, ap_continue, operand_valid, slice_done, drain_ready,
        output ap_idle, ap_ready, ap_done, operand_req, tile_m, tile_n, tile_k,
               slice_pe_reset, slice_start, drain_valid, drain_m, drain_n, err_timeout
    );

    modport slave (
        output ap_start, ap_continue, operand_valid, slice_done, drain_ready,
        input  ap_idle, ap_ready, ap_done, operand_req, tile_m, tile_n, tile_k,
               slice_pe_reset, slice_start, drain_valid, drain_m, drain_n, err_timeout
    );
endinterface

// File: rtl/slice_grid_scheduler.sv
// Walks output tiles (m outer, n middle) and reduction tiles (k inner) for the 2x2
// tensor-slice grid: fetch operands, clear PEs at k=0, run until all slices report done, drain.
module slice_grid_scheduler #(
    parameter int M_TILES        = 2,
    parameter int N_TILES        = 2,
    parameter int K_TILES        = 2,
    parameter int NUM_SLICES     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    slice_grid_scheduler_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [3:0]            tile_m;
    logic [3:0]            tile_n;
    logic [3:0]            tile_k;
    logic [NUM_SLICES-1:0] done_mask;
    logic [CNT_W-1:0]      run_cnt;
    logic                  err_timeout;

    logic mask_all;
    logic timeout_hit;
    logic last_k;
    logic last_n;
    logic last_tile;

    // Done bits are merged with the live inputs so a slice finishing this cycle counts now.
    assign mask_all    = &(done_mask | bus.slice_done);
    assign timeout_hit = (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign last_k      = (tile_k == 4'(K_TILES - 1));
    assign last_n      = (tile_n == 4'(N_TILES - 1));
    assign last_tile   = last_n && (tile_m == 4'(M_TILES - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (bus.ap_start) state_next = FETCH;
            FETCH: if (bus.operand_valid) state_next = (tile_k == 4'd0) ? CLEAR : RUN;
            CLEAR: state_next = RUN;
            RUN: begin
                if (mask_all)         state_next = last_k ? DRAIN : FETCH;
                else if (timeout_hit) state_next = DONE;
            end
            DRAIN: if (bus.drain_ready) state_next = last_tile ? DONE : FETCH;
            DONE:  if (bus.ap_continue) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= IDLE;
            tile_m      <= '0;
            tile_n      <= '0;
            tile_k      <= '0;
            done_mask   <= '0;
            run_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_next;
            // The counter idles at zero outside RUN, so every RUN entry starts fresh.
            run_cnt <= (state == RUN) ? run_cnt + CNT_W'(1) : '0;
            case (state)
                IDLE: begin
                    if (bus.ap_start) begin
                        tile_m      <= '0;
                        tile_n      <= '0;
                        tile_k      <= '0;
                        done_mask   <= '0;
                        err_timeout <= 1'b0;
                    end
                end
                RUN: begin
                    if (mask_all) begin
                        done_mask <= '0;
                        if (!last_k) tile_k <= tile_k + 4'd1;
                    end else if (timeout_hit) begin
                        done_mask   <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        done_mask <= done_mask | bus.slice_done;
                    end
                end
                DRAIN: begin
                    if (bus.drain_ready) begin
                        tile_k <= '0;
                        if (last_n) begin
                            tile_n <= '0;
                            tile_m <= last_tile ? 4'd0 : tile_m + 4'd1;
                        end else begin
                            tile_n <= tile_n + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ap_idle        = (state == IDLE);
    assign bus.ap_ready       = (state == IDLE);
    assign bus.ap_done        = (state == DONE);
    assign bus.operand_req    = (state == FETCH);
    assign bus.slice_pe_reset = (state == CLEAR);
    assign bus.slice_start    = {NUM_SLICES{state == RUN}};
    assign bus.drain_valid    = (state == DRAIN);
    assign bus.drain_m        = tile_m;
    assign bus.drain_n        = tile_n;
    assign bus.tile_m         = tile_m;
    assign bus.tile_n         = tile_n;
    assign bus.tile_k         = tile_k;
    assign bus.err_timeout    = err_timeout;
endmodule
